rtc_countdown: RTL

- BCD countdown timer with 10 ms resolution: loads an MM:SS.cc value and decrements it once per hundredth of a second.
- Stops at 00:00.00 and raises a sticky alarm.
- Companion to the BCD stopwatch: same i_ckstep fractional-step timebase, same digit limits, but counts down instead of up.
- Sits beside the stopwatch in the RTC core; the core's bus decode drives its command strobes.

---
 rtl/rtc_countdown_if.sv | 22 ++
 rtl/rtc_countdown.sv | 113 +++++++++++
 2 files changed

// File: rtl/rtc_countdown_if.sv
// Command and status bundle between the RTC bus decode (master) and the
// countdown timer (slave).
interface rtc_countdown_if;
   logic [31:0] i_ckstep;
   logic        i_load;
   logic [23:0] i_load_value;
   logic        i_start;
   logic        i_stop;
   logic        i_clear_alarm;
   logic [23:0] o_value;
   logic        o_running;
   logic        o_alarm;

   modport master (
      output i_ckstep, i_load, i_load_value, i_start, i_stop, i_clear_alarm,
      input  o_value, o_running, o_alarm
   );
   modport slave (
      input  i_ckstep, i_load, i_load_value, i_start, i_stop, i_clear_alarm,
      output o_value, o_running, o_alarm
   );
endinterface

// File: rtl/rtc_countdown.sv
// BCD MM:SS.cc countdown timer with 10 ms resolution, driven by a 48-bit
// fractional phase accumulator; stops (or reloads) at zero with a sticky alarm.
module rtc_countdown #(
   parameter bit OPT_AUTORELOAD = 1'b0
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   rtc_countdown_if.slave bus
);
   localparam int NDIG = 6;
   // Digit 0 is hundredths, digit 5 is tens of minutes.
   localparam logic [NDIG-1:0][3:0] LIM = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

   typedef enum logic {IDLE, RUN} state_e;
   state_e state_q, state_d;

   logic [38:0]          step_q;
   logic [47:0]          acc_q, acc_d;
   logic [48:0]          sum;
   logic                 tick_q, tick_d;
   logic                 alarm_q, alarm_d;
   logic [NDIG-1:0][3:0] value_q, value_d;
   logic [NDIG-1:0][3:0] reload_q, reload_d;
   logic [NDIG-1:0][3:0] clamped, dec_val;
   logic [NDIG-1:0]      zero_dig;

   genvar g;
   generate
      for (g = 0; g < NDIG; g++) begin : g_dig
         logic brw;
         if (g == 0) begin : g_lsd
            assign brw = 1'b1;
         end else begin : g_upper
            // A digit borrows only when every digit below it is zero.
            assign brw = &zero_dig[g-1:0];
         end
         assign zero_dig[g] = (value_q[g] == 4'd0);
         assign clamped[g]  = (bus.i_load_value[g*4 +: 4] > LIM[g]) ? LIM[g]
                                                                   : bus.i_load_value[g*4 +: 4];
         assign dec_val[g]  = !brw        ? value_q[g] :
                              zero_dig[g] ? LIM[g]     : value_q[g] - 4'd1;
      end
   endgenerate

   assign sum = {1'b0, acc_q} + {10'd0, step_q};

   always_comb begin
      state_d  = state_q;
      value_d  = value_q;
      reload_d = reload_q;
      alarm_d  = alarm_q;
      acc_d    = acc_q;
      tick_d   = 1'b0;
      if (state_q == RUN) begin
         acc_d  = sum[47:0];
         tick_d = sum[48];
      end
      if (bus.i_clear_alarm) alarm_d = 1'b0;

      if (bus.i_load) begin
         value_d  = clamped;
         reload_d = clamped;
         state_d  = IDLE;
         alarm_d  = 1'b0;
         acc_d    = '0;
         tick_d   = 1'b0;
      end else if (bus.i_stop) begin
         state_d = IDLE;
      end else if (state_q == RUN) begin
         if (tick_q) begin
            if (dec_val == '0) begin
               // Reaching zero beats a same-cycle alarm clear.
               alarm_d = 1'b1;
               if (OPT_AUTORELOAD) begin
                  value_d = reload_q;
                  if (reload_q == '0) state_d = IDLE;
               end else begin
                  value_d = '0;
                  state_d = IDLE;
               end
            end else begin
               value_d = dec_val;
            end
         end
      end else if (bus.i_start && value_q != '0) begin
         state_d = RUN;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q  <= IDLE;
         step_q   <= '0;
         acc_q    <= '0;
         tick_q   <= 1'b0;
         alarm_q  <= 1'b0;
         value_q  <= '0;
         reload_q <= '0;
      end else begin
         state_q  <= state_d;
         step_q   <= 39'(bus.i_ckstep) * 39'd100;
         acc_q    <= acc_d;
         tick_q   <= tick_d;
         alarm_q  <= alarm_d;
         value_q  <= value_d;
         reload_q <= reload_d;
      end
   end

   assign bus.o_value   = value_q;
   assign bus.o_running = (state_q == RUN);
   assign bus.o_alarm   = alarm_q;
endmodule
